regfile_arbiter: RTL and testbench
==================================

// Module: regfile_arbiter
// PURPOSE
//  Two-port round-robin arbiter/sequencer in front of the single-port register_file (WrEn/RdEn/address/WrData/RdData).
//  Two requesters issue read or write commands over valid/ready. The block serialises them, drives exactly one
//  one-cycle RF enable per command, and returns a response (read data, or write done) to the owning requester.
// PARAMETERS
//  ADDR_WIDTH  3   RF address width (RF depth = 2**ADDR_WIDTH)
//  DATA_WIDTH  16  RF word width
// PORTS
//  clk          in   1           clock, all logic on rising edge
//  rst          in   1           synchronous, active-high reset
//  reqN_valid   in   1           N=0,1: command valid; held with payload stable until reqN_ready
//  reqN_wr      in   1           1=write, 0=read
//  reqN_addr    in   ADDR_WIDTH  target RF address
//  reqN_wdata   in   DATA_WIDTH  write data (ignored for reads)
//  reqN_ready   out  1           command accepted this cycle (valid&ready = transfer)
//  rspN_valid   out  1           one-cycle response pulse to requester N
//  rspN_rdata   out  DATA_WIDTH  read data (valid with rspN_valid on reads; 0 on writes)
//  rf_WrEn      out  1           to RF WrEn
//  rf_RdEn      out  1           to RF RdEn
//  rf_address   out  ADDR_WIDTH  to RF address
//  rf_WrData    out  DATA_WIDTH  to RF WrData
//  rf_RdData    in   DATA_WIDTH  from RF RdData (registered in RF, valid 1 cycle after RdEn)
//  busy         out  1           state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, prio=0. All outputs 0: ready, rsp, rf enables, rf_address/WrData, rdata, busy.
//  FSM: IDLE -> ISSUE -> (write) RESP | (read) WAIT -> RESP -> IDLE.
//   IDLE: Combinationally assert reqN_ready for the granted requester only, never both.
//     - One valid: grant it, regardless of prio.
//     - Both valid: grant the requester at prio.
//     - On transfer: latch wr/addr/wdata and owner; go to ISSUE.
//   ISSUE (1 cycle): drive rf_address/rf_WrData from the latch.
//     - Pulse rf_WrEn (write) or rf_RdEn (read) high for this cycle only.
//   WAIT (1 cycle, reads only): RF presents RdData; capture it into the rsp data register.
//   RESP (1 cycle): pulse rspOwner_valid; rspOwner_rdata = captured data (read) or 0 (write).
//     - Set prio = ~owner. Go to IDLE.
//  Latency from transfer cycle A:
//   - RF enable in A+1.
//   - Write rsp in A+2; read rsp in A+3.
//   - Next transfer no earlier than the cycle after RESP.
//  Invariants:
//   - rf_WrEn & rf_RdEn never both 1.
//   - Enables are 0 outside ISSUE.
//   - rf_address/rf_WrData hold their last latched values otherwise.
//  A non-owner's valid is simply stalled (ready=0); its command is never dropped or reordered.
//  Same-address write then read from either requester returns the new data (strict serialisation).
//  rst mid-transaction (any state): next cycle IDLE, prio=0, all outputs 0.
//   - No response is issued for the aborted command; RF contents are not touched by this block.
// TESTING
//  1. Hold rst 2 cycles, all req*_valid=0 -> every output 0, busy=0.
//  2. req0 write addr=3 data=16'hA93C -> ready0 @A, rf_WrEn=1/addr=3 @A+1, rsp0_valid @A+2.
//     Then req0 read addr=3 -> rsp0_valid @A+3, rsp0_rdata=16'hA93C.
//  3. From reset, req0 and req1 both continuously valid with writes to addr 0/1
//     -> grant order 0,1,0,1; rf_WrEn pulses one at a time.
//  4. Only req1 valid, three back-to-back reads of addr 7,5,1 (preloaded 16'hFF90,16'hFFFF,16'hF0AA)
//     -> all granted to req1, rsp1_rdata in that order.
//  5. req0 read accepted, rst=1 in WAIT cycle -> no rsp0_valid; next cycle all outputs 0, busy=0.
//     A subsequent req1 write proceeds normally.
//  6. Throughout all tests assert: rf_WrEn&rf_RdEn==0; each enable is a single-cycle pulse per transfer;
//     reqN_ready is never high for both requesters at once.

Source files
------------

// File: rtl/regfile_arbiter_if.sv
// rtl/regfile_arbiter_if.sv - two-requester command/response bundle for the register-file arbiter
interface regfile_arbiter_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 16
);
    logic                  req0_valid;
    logic                  req0_wr;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;
    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_rdata;

    logic                  req1_valid;
    logic                  req1_wr;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_rdata;

    modport master (
        output req0_valid, req0_wr, req0_addr, req0_wdata,
        output req1_valid, req1_wr, req1_addr, req1_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata
    );

    modport slave (
        input  req0_valid, req0_wr, req0_addr, req0_wdata,
        input  req1_valid, req1_wr, req1_addr, req1_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata
    );
endinterface

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - round-robin sequencer serialising two requesters onto a single-port register file
module regfile_arbiter #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_arbiter_if.slave      req,
    output logic                  rf_WrEn,
    output logic                  rf_RdEn,
    output logic [ADDR_WIDTH-1:0] rf_address,
    output logic [DATA_WIDTH-1:0] rf_WrData,
    input  logic [DATA_WIDTH-1:0] rf_RdData,
    output logic                  busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    logic                  r_prio;
    logic                  r_owner;
    logic                  r_wr;
    logic                  r_wr_en;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rsp0_valid;
    logic                  r_rsp1_valid;
    logic [DATA_WIDTH-1:0] r_rsp0_rdata;
    logic [DATA_WIDTH-1:0] r_rsp1_rdata;

    logic                  w_idle;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_sel_wr;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    // Ready is withheld while rst is high so no command is accepted and then lost.
    assign w_idle      = (r_state == S_IDLE) && !rst;
    assign w_gnt0      = w_idle && req.req0_valid && (!req.req1_valid || !r_prio);
    assign w_gnt1      = w_idle && req.req1_valid && (!req.req0_valid ||  r_prio);
    assign w_sel_wr    = w_gnt1 ? req.req1_wr    : req.req0_wr;
    assign w_sel_addr  = w_gnt1 ? req.req1_addr  : req.req0_addr;
    assign w_sel_wdata = w_gnt1 ? req.req1_wdata : req.req0_wdata;

    assign req.req0_ready = w_gnt0;
    assign req.req1_ready = w_gnt1;
    assign req.rsp0_valid = r_rsp0_valid;
    assign req.rsp1_valid = r_rsp1_valid;
    assign req.rsp0_rdata = r_rsp0_rdata;
    assign req.rsp1_rdata = r_rsp1_rdata;

    assign rf_WrEn    = r_wr_en;
    assign rf_RdEn    = r_rd_en;
    assign rf_address = r_addr;
    assign rf_WrData  = r_wdata;
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_prio       <= 1'b0;
            r_owner      <= 1'b0;
            r_wr         <= 1'b0;
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_owner <= w_gnt1;
                        r_wr    <= w_sel_wr;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_wr_en <= w_sel_wr;
                        r_rd_en <= !w_sel_wr;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_wr) begin
                        r_rsp0_valid <= !r_owner;
                        r_rsp1_valid <= r_owner;
                        r_rsp0_rdata <= '0;
                        r_rsp1_rdata <= '0;
                        r_state      <= S_RESP;
                    end else begin
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // RF registered its read on the ISSUE edge, so RdData is valid now.
                    r_rsp0_valid <= !r_owner;
                    r_rsp1_valid <= r_owner;
                    if (r_owner) r_rsp1_rdata <= rf_RdData;
                    else         r_rsp0_rdata <= rf_RdData;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_rsp0_rdata <= '0;
                    r_rsp1_rdata <= '0;
                    r_prio       <= !r_owner;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - randomized and directed bench for regfile_arbiter against a transaction-level model
module tb_regfile_arbiter;
    logic        clk;
    logic        rst;
    logic        rf_WrEn;
    logic        rf_RdEn;
    logic [2:0]  rf_address;
    logic [15:0] rf_WrData;
    logic [15:0] rf_RdData;
    logic        busy;

    regfile_arbiter_if #(.ADDR_WIDTH(3), .DATA_WIDTH(16)) ifc ();

    regfile_arbiter #(.ADDR_WIDTH(3), .DATA_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (ifc.slave),
        .rf_WrEn    (rf_WrEn),
        .rf_RdEn    (rf_RdEn),
        .rf_address (rf_address),
        .rf_WrData  (rf_WrData),
        .rf_RdData  (rf_RdData),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stand-in single-port register file with registered read
    logic [15:0] rf_mem [8];
    initial begin
        for (int i = 0; i < 8; i++) rf_mem[i] = 16'h0;
        rf_RdData = 16'h0;
    end
    always @(posedge clk) begin
        if (rf_WrEn) rf_mem[rf_address] <= rf_WrData;
        if (rf_RdEn) rf_RdData <= rf_mem[rf_address];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // transaction-level reference: memory contents, fairness pointer, one in-flight command
    logic [15:0] ref_mem [8];
    initial for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0;
    int          cyc = 0;
    int          next_free = 0;
    bit          prio = 0;
    bit          after_rst = 0;
    bit          inf_valid = 0;
    bit          inf_owner;
    bit          inf_wr;
    logic [2:0]  inf_addr;
    logic [15:0] inf_wdata;
    logic [15:0] inf_rdata;
    int          inf_issue;
    int          inf_rsp;
    bit [1:0]    xfer = 2'b00;
    int          stall0 = 0;
    int          stall1 = 0;
    int          grant_log[$];

    always @(negedge clk) begin
        bit free, e_r0, e_r1, e_we, e_re, e_v0, e_v1, v0, v1;
        v0 = ifc.req0_valid;
        v1 = ifc.req1_valid;
        if (rst) begin
            check_eq("ready0_in_rst", 32'(ifc.req0_ready), 32'd0);
            check_eq("ready1_in_rst", 32'(ifc.req1_ready), 32'd0);
            inf_valid = 0;
            next_free = cyc + 1;
            prio      = 0;
            after_rst = 1;
            xfer      = 2'b00;
            stall0    = 0;
            stall1    = 0;
        end else begin
            if (after_rst) begin
                check_eq("rst_wren",  32'(rf_WrEn), 32'd0);
                check_eq("rst_rden",  32'(rf_RdEn), 32'd0);
                check_eq("rst_addr",  32'(rf_address), 32'd0);
                check_eq("rst_wdata", 32'(rf_WrData), 32'd0);
                check_eq("rst_rsp0",  32'(ifc.rsp0_valid), 32'd0);
                check_eq("rst_rsp1",  32'(ifc.rsp1_valid), 32'd0);
                check_eq("rst_rdat0", 32'(ifc.rsp0_rdata), 32'd0);
                check_eq("rst_rdat1", 32'(ifc.rsp1_rdata), 32'd0);
                after_rst = 0;
            end
            free = (cyc >= next_free);
            e_r0 = free && v0 && (!v1 || !prio);
            e_r1 = free && v1 && (!v0 ||  prio);
            check_eq("ready0", 32'(ifc.req0_ready), 32'(e_r0));
            check_eq("ready1", 32'(ifc.req1_ready), 32'(e_r1));
            check_eq("ready_both", 32'(ifc.req0_ready & ifc.req1_ready), 32'd0);
            check_eq("busy", 32'(busy), 32'(!free));
            check_eq("en_both", 32'(rf_WrEn & rf_RdEn), 32'd0);

            e_we = inf_valid && (cyc == inf_issue) &&  inf_wr;
            e_re = inf_valid && (cyc == inf_issue) && !inf_wr;
            check_eq("rf_wren", 32'(rf_WrEn), 32'(e_we));
            check_eq("rf_rden", 32'(rf_RdEn), 32'(e_re));
            if (e_we || e_re) check_eq("rf_addr", 32'(rf_address), 32'(inf_addr));
            if (e_we)         check_eq("rf_wdata", 32'(rf_WrData), 32'(inf_wdata));

            e_v0 = inf_valid && (cyc == inf_rsp) && !inf_owner;
            e_v1 = inf_valid && (cyc == inf_rsp) &&  inf_owner;
            check_eq("rsp0_valid", 32'(ifc.rsp0_valid), 32'(e_v0));
            check_eq("rsp1_valid", 32'(ifc.rsp1_valid), 32'(e_v1));
            if (e_v0) check_eq("rsp0_rdata", 32'(ifc.rsp0_rdata), 32'(inf_rdata));
            if (e_v1) check_eq("rsp1_rdata", 32'(ifc.rsp1_rdata), 32'(inf_rdata));
            if (inf_valid && cyc == inf_rsp) begin
                prio      = !inf_owner;
                inf_valid = 0;
            end

            xfer = {e_r1, e_r0};
            if (e_r0 || e_r1) begin
                inf_valid = 1;
                inf_owner = e_r1;
                inf_wr    = e_r1 ? ifc.req1_wr    : ifc.req0_wr;
                inf_addr  = e_r1 ? ifc.req1_addr  : ifc.req0_addr;
                inf_wdata = e_r1 ? ifc.req1_wdata : ifc.req0_wdata;
                inf_issue = cyc + 1;
                inf_rsp   = cyc + (inf_wr ? 2 : 3);
                inf_rdata = inf_wr ? 16'h0 : ref_mem[inf_addr];
                if (inf_wr) ref_mem[inf_addr] = inf_wdata;
                next_free = inf_rsp + 1;
                grant_log.push_back(int'(e_r1));
            end

            stall0 = (v0 && !e_r0) ? stall0 + 1 : 0;
            stall1 = (v1 && !e_r1) ? stall1 + 1 : 0;
            if (stall0 == 13) check_eq("starve0", 32'(stall0), 32'd12);
            if (stall1 == 13) check_eq("starve1", 32'(stall1), 32'd12);
        end
        cyc++;
    end

    task automatic drive(input int n, input logic v, input logic w, input logic [2:0] a, input logic [15:0] d);
        if (n == 0) begin
            ifc.req0_valid = v; ifc.req0_wr = w; ifc.req0_addr = a; ifc.req0_wdata = d;
        end else begin
            ifc.req1_valid = v; ifc.req1_wr = w; ifc.req1_addr = a; ifc.req1_wdata = d;
        end
    endtask

    task automatic issue(input int n, input logic w, input logic [2:0] a, input logic [15:0] d);
        bit got;
        got = 0;
        @(posedge clk); #1;
        drive(n, 1'b1, w, a, d);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (xfer[n]) begin
                got = 1;
                break;
            end
        end
        check_eq("xfer_timeout", 32'(got), 32'd1);
        #1;
        drive(n, 1'b0, 1'b0, 3'd0, 16'h0);
    endtask

    initial begin
        int cnt;
        int base;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 3'd0, 16'h0);
        drive(1, 1'b0, 1'b0, 3'd0, 16'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // both requesters continuously valid from reset: grants must alternate starting with 0
        #1;
        base = grant_log.size();
        drive(0, 1'b1, 1'b1, 3'd0, 16'($urandom));
        drive(1, 1'b1, 1'b1, 3'd1, 16'($urandom));
        cnt = 0;
        for (int i = 0; i < 60 && cnt < 4; i++) begin
            @(posedge clk); #1;
            if (xfer[0]) begin cnt++; ifc.req0_wdata = 16'($urandom); end
            if (xfer[1]) begin cnt++; ifc.req1_wdata = 16'($urandom); end
        end
        drive(0, 1'b0, 1'b0, 3'd0, 16'h0);
        drive(1, 1'b0, 1'b0, 3'd0, 16'h0);
        check_eq("rr_count", 32'(grant_log.size() - base), 32'd4);
        if (grant_log.size() - base >= 4)
            for (int k = 0; k < 4; k++) check_eq("rr_order", 32'(grant_log[base + k]), 32'(k % 2));
        repeat (6) @(posedge clk);

        issue(0, 1'b1, 3'd3, 16'hA93C);
        issue(0, 1'b0, 3'd3, 16'h0);
        repeat (6) @(posedge clk);

        issue(0, 1'b1, 3'd7, 16'hFF90);
        issue(0, 1'b1, 3'd5, 16'hFFFF);
        issue(0, 1'b1, 3'd1, 16'hF0AA);
        base = grant_log.size();
        issue(1, 1'b0, 3'd7, 16'h0);
        issue(1, 1'b0, 3'd5, 16'h0);
        issue(1, 1'b0, 3'd1, 16'h0);
        for (int k = 0; k < 3; k++)
            if (grant_log.size() > base + k) check_eq("only_req1", 32'(grant_log[base + k]), 32'd1);
        repeat (6) @(posedge clk);

        // abort a read in its WAIT cycle; no response may follow
        issue(0, 1'b0, 3'd3, 16'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        issue(1, 1'b1, 3'd2, 16'h1234);
        issue(1, 1'b0, 3'd2, 16'h0);
        repeat (6) @(posedge clk);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            for (int n = 0; n < 2; n++) begin
                bit cur_v;
                cur_v = (n == 0) ? ifc.req0_valid : ifc.req1_valid;
                if (!cur_v || xfer[n])
                    drive(n, ($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom));
            end
        end
        drive(0, 1'b0, 1'b0, 3'd0, 16'h0);
        drive(1, 1'b0, 1'b0, 3'd0, 16'h0);
        repeat (8) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
